// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the
// iterative multiply/divide sequencer.
package muldiv_pkg;

   localparam int MD_WIDTH = 32;
   localparam int MD_CNT_W = $clog2(MD_WIDTH) + 1;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_FIX  = 2'b10
   } md_state_e;

   function automatic logic is_div_op(input md_op_e op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic is_signed_op(input md_op_e op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration, shift-add for
// multiply or restoring trial-subtract for divide.
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic                 is_div,
   input  logic [2*WIDTH-1:0]   acc_i,
   input  logic [WIDTH-1:0]     opnd_i,
   output logic [2*WIDTH-1:0]   acc_o
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] rem_sh;
   logic [WIDTH:0] trial;

   // The remainder stays below the divisor, so the top
   // bit of the trial difference is the borrow.
   always_comb begin
      sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
             + (acc_i[0] ? {1'b0, opnd_i} : '0);
      rem_sh = acc_i[2*WIDTH-1:WIDTH-1];
      trial  = rem_sh - {1'b0, opnd_i};
      if (is_div) begin
         if (!trial[WIDTH]) begin
            acc_o = {trial[WIDTH-1:0],
                     acc_i[WIDTH-2:0], 1'b1};
         end else begin
            acc_o = {rem_sh[WIDTH-1:0],
                     acc_i[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_o = {sum, acc_i[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: HI/LO owner, runs MULT/MULTU/DIV/DIVU
// over WIDTH cycles and stalls dependent requests.
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mt_en,
   input  logic             mt_sel,
   input  logic [WIDTH-1:0] mt_data,
   input  logic             rd_req,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic             stall
);

   localparam int CW = $clog2(WIDTH) + 1;

   md_state_e          state_q, state_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic               div_q, div_d;
   logic               neg_q, neg_d;
   logic               neg_rem_q, neg_rem_d;
   logic               dz_pend_q, dz_pend_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;
   logic               dzero_q, dzero_d;

   md_op_e             op_e;
   logic               op_div;
   logic               op_sgn;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [2*WIDTH-1:0] step_acc;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix;
   logic [WIDTH-1:0]   rem_fix;

   assign op_e   = md_op_e'(op);
   assign op_div = is_div_op(op_e);
   assign op_sgn = is_signed_op(op_e);

   // Magnitudes for signed ops; 0x80000000 maps to itself
   // and is then treated as unsigned.
   always_comb begin
      a_mag = (op_sgn && a[WIDTH-1]) ? -a : a;
      b_mag = (op_sgn && b[WIDTH-1]) ? -b : b;
   end

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div (div_q),
      .acc_i  (acc_q),
      .opnd_i (opnd_q),
      .acc_o  (step_acc)
   );

   // Sign correction applied to the raw loop result.
   always_comb begin
      prod_fix = neg_q ? -acc_q : acc_q;
      quot_fix = neg_q ? -acc_q[WIDTH-1:0]
                       : acc_q[WIDTH-1:0];
      rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH]
                           : acc_q[2*WIDTH-1:WIDTH];
   end

   // Next-state: issue capture, iteration, HI/LO write.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      div_d     = div_q;
      neg_d     = neg_q;
      neg_rem_d = neg_rem_q;
      dz_pend_d = dz_pend_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      dzero_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               div_d     = op_div;
               neg_d     = op_sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
               neg_rem_d = op_sgn & op_div & a[WIDTH-1];
               cnt_d     = '0;
               if (op_div && (b == '0)) begin
                  dz_pend_d = 1'b1;
                  acc_d     = {{WIDTH{1'b0}}, a};
                  opnd_d    = '0;
                  state_d   = S_FIX;
               end else begin
                  dz_pend_d = 1'b0;
                  state_d   = S_RUN;
                  if (op_div) begin
                     acc_d  = {{WIDTH{1'b0}}, a_mag};
                     opnd_d = b_mag;
                  end else begin
                     acc_d  = {{WIDTH{1'b0}}, b_mag};
                     opnd_d = a_mag;
                  end
               end
            end else if (mt_en) begin
               if (mt_sel) hi_d = mt_data;
               else        lo_d = mt_data;
            end
         end
         S_RUN: begin
            acc_d = step_acc;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
         end
         S_FIX: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            if (dz_pend_q) begin
               hi_d    = acc_q[WIDTH-1:0];
               lo_d    = '1;
               dzero_d = 1'b1;
            end else if (div_q) begin
               hi_d = rem_fix;
               lo_d = quot_fix;
            end else begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and HI/LO registers; reset drops any operation.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         acc_q     <= '0;
         opnd_q    <= '0;
         div_q     <= 1'b0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_pend_q <= 1'b0;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
         dzero_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         opnd_q    <= opnd_d;
         div_q     <= div_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
         dz_pend_q <= dz_pend_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
         dzero_q   <= dzero_d;
      end
   end

   assign hi       = hi_q;
   assign lo       = lo_q;
   assign busy     = (state_q != S_IDLE);
   assign done     = done_q;
   assign div_zero = dzero_q;
   assign stall    = busy & (start | rd_req | mt_en);

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: scoreboard bench for muldiv_seq,
// expected HI/LO from a longint reference model.
module tb_muldiv_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        mt_en;
   logic        mt_sel;
   logic [31:0] mt_data;
   logic        rd_req;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic        stall;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } exp_t;

   exp_t sbq[$];

   muldiv_seq u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .mt_en    (mt_en),
      .mt_sel   (mt_sel),
      .mt_data  (mt_data),
      .rd_req   (rd_req),
      .hi       (hi),
      .lo       (lo),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .stall    (stall)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [1:0] o,
                                  input logic [31:0] x,
                                  input logic [31:0] y);
      exp_t e;
      longint sx, sy, p, q, r;
      longint unsigned ux, uy, up, uq, ur;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'd0, x};
      uy = {32'd0, y};
      e  = '0;
      if (o[1] && y == 32'd0) begin
         e.hi = x;
         e.lo = 32'hFFFF_FFFF;
         e.dz = 1'b1;
         return e;
      end
      case (o)
         2'b00: begin
            p = sx * sy;
            e.hi = p[63:32];
            e.lo = p[31:0];
         end
         2'b01: begin
            up = ux * uy;
            e.hi = up[63:32];
            e.lo = up[31:0];
         end
         2'b10: begin
            q = sx / sy;
            r = sx % sy;
            e.lo = q[31:0];
            e.hi = r[31:0];
         end
         default: begin
            uq = ux / uy;
            ur = ux % uy;
            e.lo = uq[31:0];
            e.hi = ur[31:0];
         end
      endcase
      return e;
   endfunction

   // Issue at the current negedge, wait for done.
   task automatic run_op(input  logic [1:0]  o,
                         input  logic [31:0] x,
                         input  logic [31:0] y,
                         output logic [31:0] rhi,
                         output logic [31:0] rlo,
                         output logic        rdz,
                         output logic [31:0] hi0,
                         output logic [31:0] lo0,
                         output logic        busy0,
                         output logic        bdone,
                         output int          lat);
      sbq.push_back(model(o, x, y));
      op = o;
      a = x;
      b = y;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      mt_en = 1'b0;
      hi0 = hi;
      lo0 = lo;
      busy0 = busy;
      lat = -1;
      rhi = hi;
      rlo = lo;
      rdz = div_zero;
      bdone = busy;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (done) begin
            lat = n;
            rhi = hi;
            rlo = lo;
            rdz = div_zero;
            bdone = busy;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      start = 1'b0;
      op = 2'b00;
      a = '0;
      b = '0;
      mt_en = 1'b0;
      mt_sel = 1'b0;
      mt_data = '0;
      rd_req = 1'b0;
      #12;
      checks++;
      if ({hi, lo, busy, done, div_zero, stall} !== '0) begin
         failures++;
         $display("FAIL reset hi=%h lo=%h b=%b d=%b z=%b s=%b",
                  hi, lo, busy, done, div_zero, stall);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_ops(input bit do_div);
      logic [1:0]  to [8];
      logic [31:0] ta [8];
      logic [31:0] tb [8];
      logic [31:0] rhi, rlo, hi0, lo0, phi, plo;
      logic        rdz, busy0, bdone;
      int          lat;
      exp_t        e;
      if (!do_div) begin
         to[0] = 2'b01; ta[0] = 32'hFFFF_FFFF; tb[0] = 32'hFFFF_FFFF;
         to[1] = 2'b00; ta[1] = 32'hFFFF_FFFD; tb[1] = 32'd7;
         to[2] = 2'b00; ta[2] = 32'h8000_0000; tb[2] = 32'h8000_0000;
         to[3] = 2'b00; ta[3] = 32'h8000_0000; tb[3] = 32'd1;
         to[4] = 2'b01; ta[4] = 32'd0;         tb[4] = 32'h1234_5678;
      end else begin
         to[0] = 2'b10; ta[0] = 32'hFFFF_FFF9; tb[0] = 32'd2;
         to[1] = 2'b11; ta[1] = 32'd7;         tb[1] = 32'd2;
         to[2] = 2'b10; ta[2] = 32'h8000_0000; tb[2] = 32'hFFFF_FFFF;
         to[3] = 2'b10; ta[3] = 32'd7;         tb[3] = 32'hFFFF_FFFE;
         to[4] = 2'b11; ta[4] = 32'hFFFF_FFFF; tb[4] = 32'd1;
      end
      for (int i = 5; i < 8; i++) begin
         to[i] = {do_div, 1'($urandom_range(0, 1))};
         ta[i] = $urandom;
         tb[i] = $urandom;
         if (tb[i] == 32'd0) tb[i] = 32'd3;
      end
      for (int i = 0; i < 8; i++) begin
         phi = hi;
         plo = lo;
         run_op(to[i], ta[i], tb[i], rhi, rlo, rdz,
                hi0, lo0, busy0, bdone, lat);
         e = sbq.pop_front();
         checks++;
         if (rhi !== e.hi || rlo !== e.lo || rdz !== e.dz) begin
            failures++;
            $display("FAIL op%0d_%0d got %h_%h z%b want %h_%h z%b",
                     to[i], i, rhi, rlo, rdz, e.hi, e.lo, e.dz);
         end
         checks++;
         if (lat !== 33 || bdone !== 1'b0) begin
            failures++;
            $display("FAIL latency_%0d got %0d busy=%b want 33 busy=0",
                     i, lat, bdone);
         end
         checks++;
         if (busy0 !== 1'b1 || hi0 !== phi || lo0 !== plo) begin
            failures++;
            $display("FAIL run_stable_%0d busy=%b hi=%h lo=%h want 1 %h %h",
                     i, busy0, hi0, lo0, phi, plo);
         end
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || div_zero !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse_%0d done=%b dz=%b want 0 0",
                     i, done, div_zero);
         end
      end
   endtask

   task automatic test_div_zero();
      logic [31:0] rhi, rlo, hi0, lo0;
      logic        rdz, busy0, bdone;
      int          lat;
      exp_t        e;
      run_op(2'b11, 32'd5, 32'd0, rhi, rlo, rdz,
             hi0, lo0, busy0, bdone, lat);
      e = sbq.pop_front();
      checks++;
      if (rhi !== e.hi || rlo !== e.lo || rdz !== e.dz || lat !== 1) begin
         failures++;
         $display("FAIL divu_zero got %h_%h z%b lat%0d want %h_%h z%b lat1",
                  rhi, rlo, rdz, lat, e.hi, e.lo, e.dz);
      end
      run_op(2'b10, 32'h8000_0000, 32'd0, rhi, rlo, rdz,
             hi0, lo0, busy0, bdone, lat);
      e = sbq.pop_front();
      checks++;
      if (rhi !== e.hi || rlo !== e.lo || rdz !== e.dz || lat !== 1) begin
         failures++;
         $display("FAIL div_zero got %h_%h z%b lat%0d want %h_%h z%b lat1",
                  rhi, rlo, rdz, lat, e.hi, e.lo, e.dz);
      end
      @(negedge clk);
   endtask

   task automatic test_mt();
      logic [31:0] rhi, rlo, hi0, lo0;
      logic        rdz, busy0, bdone;
      int          lat;
      exp_t        e;
      logic [31:0] plo;
      plo = lo;
      mt_en = 1'b1;
      mt_sel = 1'b1;
      mt_data = 32'h0000_1234;
      @(negedge clk);
      mt_en = 1'b0;
      checks++;
      if (hi !== 32'h0000_1234 || lo !== plo || stall !== 1'b0) begin
         failures++;
         $display("FAIL mthi hi=%h lo=%h s=%b want 00001234 %h 0",
                  hi, lo, stall, plo);
      end
      mt_en = 1'b1;
      mt_sel = 1'b0;
      mt_data = 32'hABCD_0001;
      @(negedge clk);
      mt_en = 1'b0;
      checks++;
      if (lo !== 32'hABCD_0001 || hi !== 32'h0000_1234) begin
         failures++;
         $display("FAIL mtlo hi=%h lo=%h want 00001234 abcd0001", hi, lo);
      end
      mt_en = 1'b1;
      mt_sel = 1'b0;
      mt_data = 32'hDEAD_BEEF;
      run_op(2'b01, 32'd3, 32'd5, rhi, rlo, rdz,
             hi0, lo0, busy0, bdone, lat);
      e = sbq.pop_front();
      checks++;
      if (lo0 !== 32'hABCD_0001 || rlo !== e.lo || rhi !== e.hi) begin
         failures++;
         $display("FAIL start_mt_drop lo0=%h res=%h_%h want abcd0001 %h_%h",
                  lo0, rhi, rlo, e.hi, e.lo);
      end
      @(negedge clk);
   endtask

   task automatic test_stall();
      exp_t        e;
      bit          got;
      logic [31:0] rhi, rlo;
      logic        exp_s;
      got = 1'b0;
      sbq.push_back(model(2'b01, 32'h0001_0003, 32'h0002_0005));
      op = 2'b01;
      a = 32'h0001_0003;
      b = 32'h0002_0005;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (rd_req) begin
            exp_s = (n <= 32);
            checks++;
            if (stall !== exp_s) begin
               failures++;
               $display("FAIL stall_c%0d got %b want %b", n, stall, exp_s);
            end
         end
         if (n == 33) begin
            got = 1'b1;
            e = sbq.pop_front();
            checks++;
            if (done !== 1'b1 || hi !== e.hi || lo !== e.lo) begin
               failures++;
               $display("FAIL stall_res d=%b %h_%h want 1 %h_%h",
                        done, hi, lo, e.hi, e.lo);
            end
            break;
         end
         if (n == 4) rd_req = 1'b1;
         if (n == 9) begin
            start = 1'b1;
            op = 2'b11;
            a = 32'd100;
            b = 32'd3;
         end
         if (n == 10) start = 1'b0;
      end
      rd_req = 1'b0;
      if (!got) begin
         void'(sbq.pop_front());
         checks++;
         failures++;
         $display("FAIL stall_timeout got none want done at 33");
      end
      rhi = hi;
      rlo = lo;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || hi !== rhi || lo !== rlo) begin
         failures++;
         $display("FAIL no_queue busy=%b hi=%h lo=%h want 0 %h %h",
                  busy, hi, lo, rhi, rlo);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rhi, rlo, hi0, lo0;
      logic        rdz, busy0, bdone;
      int          lat;
      exp_t        e;
      run_op(2'b00, 32'hFFFF_FF00, 32'h0000_0100, rhi, rlo, rdz,
             hi0, lo0, busy0, bdone, lat);
      e = sbq.pop_front();
      checks++;
      if (rhi !== e.hi || rlo !== e.lo || lat !== 33) begin
         failures++;
         $display("FAIL b2b_first %h_%h lat%0d want %h_%h lat33",
                  rhi, rlo, lat, e.hi, e.lo);
      end
      run_op(2'b11, 32'd1000, 32'd7, rhi, rlo, rdz,
             hi0, lo0, busy0, bdone, lat);
      e = sbq.pop_front();
      checks++;
      if (rhi !== e.hi || rlo !== e.lo || lat !== 33 || busy0 !== 1'b1) begin
         failures++;
         $display("FAIL b2b_second %h_%h lat%0d busy%b want %h_%h lat33 1",
                  rhi, rlo, lat, busy0, e.hi, e.lo);
      end
      @(negedge clk);
   endtask

   task automatic test_async_reset();
      logic [31:0] rhi, rlo, hi0, lo0;
      logic        rdz, busy0, bdone;
      int          lat;
      exp_t        e;
      mt_en = 1'b1;
      mt_sel = 1'b1;
      mt_data = 32'h5555_AAAA;
      @(negedge clk);
      mt_en = 1'b0;
      op = 2'b00;
      a = 32'h1234_5678;
      b = 32'h0000_0009;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      rd_req = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({hi, lo, busy, done, div_zero, stall} !== '0) begin
         failures++;
         $display("FAIL async_rst hi=%h lo=%h b=%b d=%b z=%b s=%b",
                  hi, lo, busy, done, div_zero, stall);
      end
      @(negedge clk);
      rst = 1'b1;
      rd_req = 1'b0;
      @(negedge clk);
      run_op(2'b01, 32'd6, 32'd7, rhi, rlo, rdz,
             hi0, lo0, busy0, bdone, lat);
      e = sbq.pop_front();
      checks++;
      if (rhi !== e.hi || rlo !== e.lo || lat !== 33) begin
         failures++;
         $display("FAIL post_rst %h_%h lat%0d want %h_%h lat33",
                  rhi, rlo, lat, e.hi, e.lo);
      end
   endtask

   initial begin
      test_reset();
      test_ops(1'b0);
      test_ops(1'b1);
      test_div_zero();
      test_mt();
      test_stall();
      test_back_to_back();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
